// File: rtl/prog_ins_memory.sv
// Program instruction store: a sequencer loads a full program through a
// valid/ready port, then the core fetches instructions with 1-cycle latency.
module prog_ins_memory #(
  parameter int word_size  = 8,
  parameter int num_ins    = 16,
  parameter int index_size = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [word_size-1:0]  load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic [index_size:0]   load_count,
  input  logic                  fetch_en,
  input  logic [index_size-1:0] prog_count,
  output logic [word_size-1:0]  ins_val,
  output logic                  ins_valid,
  output logic                  fetch_err
);

  // state | meaning
  // IDLE  | after reset, memory all zero, fetches allowed
  // LOAD  | accepting program words at the write pointer, fetches ignored
  // RUN   | program loaded, fetches allowed
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  localparam logic [index_size:0]   NumInsW = (index_size+1)'(num_ins);
  localparam logic [index_size-1:0] LastIdx = index_size'(num_ins - 1);

  state_t                 state_q, state_d;
  logic [index_size-1:0]  ptr_q, ptr_d;
  logic [index_size:0]    cnt_q, cnt_d;
  logic                   done_q, done_d;
  logic [word_size-1:0]   ins_q, ins_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;
  logic [word_size-1:0]   mem_q [num_ins];

  logic accept;
  logic fetch_ok;
  logic in_range;

  always_comb begin
    load_ready = (state_q == LOAD) && !load_start;
    accept     = load_ready && load_valid;
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    // A restart takes priority: any word offered alongside it is dropped.
    if (load_start) begin
      state_d = LOAD;
      ptr_d   = '0;
      cnt_d   = '0;
    end else if (accept) begin
      ptr_d = ptr_q + 1'b1;
      cnt_d = cnt_q + 1'b1;
      if (ptr_q == LastIdx) begin
        state_d = RUN;
        done_d  = 1'b1;
      end
    end
  end

  always_comb begin
    in_range = {1'b0, prog_count} < NumInsW;
    fetch_ok = fetch_en && (state_q != LOAD);
    vld_d    = fetch_ok;
    ins_d    = ins_q;
    err_d    = err_q;
    if (fetch_ok) begin
      err_d = !in_range;
      ins_d = in_range ? mem_q[prog_count] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      ins_q   <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      ins_q   <= ins_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < num_ins; i++) mem_q[i] <= '0;
    end else if (accept) begin
      mem_q[ptr_q] <= load_data;
    end
  end

  assign load_done  = done_q;
  assign load_count = cnt_q;
  assign ins_val    = ins_q;
  assign ins_valid  = vld_q;
  assign fetch_err  = err_q;

endmodule
